// File: rtl/mvu_dma_mc.sv
// mvu_dma_mc: multi-channel round-robin DMA packing source words into MVU buffer words, ICB-configured.
module mvu_dma_mc #(
  parameter int NCH = 2,
  parameter int SRC_AW = 32,
  parameter int SRC_DW = 32,
  parameter int DST_AW = 15,
  parameter int DST_DW = 64,
  parameter int LEN_W = 16,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic [SRC_DW-1:0] src_data,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DST_DW-1:0] dst_data,
  output logic [CW-1:0]     dst_chan,
  output logic              dst_valid,
  input  logic              dst_ready,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [31:0]       icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  input  logic [3:0]        icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [31:0]       icb_rsp_rdata,
  output logic              dma_irq
);
  localparam int RATIO = DST_DW / SRC_DW;
  localparam int KW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_FIN = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_ch, r_ptr, w_pick, w_cc;
  logic [KW-1:0]     r_k;
  logic [DST_DW-1:0] r_pack;
  logic [SRC_AW-1:0] r_src [NCH];
  logic [SRC_AW-1:0] r_wsrc [NCH];
  logic [DST_AW-1:0] r_dst [NCH];
  logic [DST_AW-1:0] r_wdst [NCH];
  logic [LEN_W-1:0]  r_len [NCH];
  logic [LEN_W-1:0]  r_wlen [NCH];
  logic [NCH-1:0]    r_busy, r_done, r_irq_en, r_err;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata, w_rd;
  logic [11:0]       w_a;
  logic [1:0]        w_off;
  logic              w_chreg, w_stat, w_acc, w_wr, w_any;

  assign w_a = icb_cmd_addr[11:0];
  assign w_off = w_a[3:2];
  assign w_cc = CW'(w_a[7:4]);
  assign w_chreg = w_a[11:8] == 4'd0 && int'(w_a[7:4]) < NCH && w_a[1:0] == 2'd0;
  assign w_stat = w_a == 12'h100;
  assign w_acc = icb_cmd_valid && !r_rsp_valid;
  assign w_wr = w_acc && !icb_cmd_read && icb_cmd_wmask == 4'hF && w_chreg;
  assign w_rd = w_stat ? 32'(r_done & r_irq_en) : !w_chreg ? 32'd0 :
                w_off == 2'd0 ? 32'(r_src[w_cc]) : w_off == 2'd1 ? 32'(r_dst[w_cc]) :
                w_off == 2'd2 ? 32'(r_len[w_cc]) :
                {28'd0, r_err[w_cc], r_irq_en[w_cc], r_done[w_cc], r_busy[w_cc]};

  // Scan downwards so the nearest busy channel after the pointer wins.
  always_comb begin
    w_pick = r_ptr;
    w_any = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      if (r_busy[CW'((int'(r_ptr) + i) % NCH)]) begin
        w_pick = CW'((int'(r_ptr) + i) % NCH);
        w_any = 1'b1;
      end
    end
  end

  assign src_valid = r_state == S_READ;
  assign src_addr = src_valid ? r_wsrc[r_ch] : '0;
  assign dst_valid = r_state == S_WRITE;
  assign dst_addr = dst_valid ? r_wdst[r_ch] : '0;
  assign dst_data = dst_valid ? r_pack : '0;
  assign dst_chan = r_ch;
  assign icb_cmd_ready = !r_rsp_valid;
  assign icb_rsp_valid = r_rsp_valid;
  assign icb_rsp_err = r_rsp_err;
  assign icb_rsp_rdata = r_rsp_rdata;
  assign dma_irq = |(r_done & r_irq_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch <= '0;
      r_ptr <= CW'(NCH - 1);
      r_k <= '0;
      r_pack <= '0;
      r_busy <= '0;
      r_done <= '0;
      r_irq_en <= '0;
      r_err <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_src[c] <= '0;
        r_wsrc[c] <= '0;
        r_dst[c] <= '0;
        r_wdst[c] <= '0;
        r_len[c] <= '0;
        r_wlen[c] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err <= !(w_chreg || w_stat);
        r_rsp_rdata <= icb_cmd_read ? w_rd : 32'd0;
      end else if (icb_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_wr) begin
        case (w_off)
          2'd0: r_src[w_cc] <= icb_cmd_wdata[SRC_AW-1:0];
          2'd1: r_dst[w_cc] <= icb_cmd_wdata[DST_AW-1:0];
          2'd2: r_len[w_cc] <= icb_cmd_wdata[LEN_W-1:0];
          default: begin
            r_irq_en[w_cc] <= icb_cmd_wdata[1];
            if (icb_cmd_wdata[2]) r_done[w_cc] <= 1'b0;
            if (icb_cmd_wdata[0]) begin
              if (r_busy[w_cc]) begin
                r_err[w_cc] <= 1'b1;
              end else if (r_len[w_cc] == '0) begin
                r_err[w_cc] <= 1'b1;
                r_done[w_cc] <= 1'b1;
              end else begin
                r_busy[w_cc] <= 1'b1;
                r_done[w_cc] <= 1'b0;
                r_err[w_cc] <= 1'b0;
                r_wsrc[w_cc] <= r_src[w_cc];
                r_wdst[w_cc] <= r_dst[w_cc];
                r_wlen[w_cc] <= r_len[w_cc];
              end
            end
          end
        endcase
      end
      // Engine updates come last so a FIN overrides a same-cycle done clear.
      case (r_state)
        S_IDLE: if (w_any) begin
          r_ch <= w_pick;
          r_ptr <= w_pick;
          r_k <= '0;
          r_state <= S_READ;
        end
        S_READ: if (src_ready) begin
          r_pack[r_k*SRC_DW +: SRC_DW] <= src_data;
          r_wsrc[r_ch] <= r_wsrc[r_ch] + SRC_AW'(SRC_DW / 8);
          r_k <= (r_k == KW'(RATIO - 1)) ? '0 : r_k + 1'b1;
          if (r_k == KW'(RATIO - 1)) r_state <= S_WRITE;
        end
        S_WRITE: if (dst_ready) begin
          r_wdst[r_ch] <= r_wdst[r_ch] + 1'b1;
          r_wlen[r_ch] <= r_wlen[r_ch] - 1'b1;
          r_state <= (r_wlen[r_ch] == LEN_W'(1)) ? S_FIN : S_READ;
        end
        default: begin
          r_busy[r_ch] <= 1'b0;
          r_done[r_ch] <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mvu_dma_mc.sv
// tb_mvu_dma_mc: register table, directed DMA sequences and randomized transfers against a transfer-level model.
module tb_mvu_dma_mc;
  localparam int NCH = 2, SRC_AW = 32, SRC_DW = 32, DST_AW = 15, DST_DW = 64, LEN_W = 16;
  localparam int R = DST_DW / SRC_DW;
  localparam int CW = 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [SRC_AW-1:0] src_addr;
  logic src_valid, src_ready, dst_valid, dst_ready;
  logic [SRC_DW-1:0] src_data;
  logic [DST_AW-1:0] dst_addr;
  logic [DST_DW-1:0] dst_data;
  logic [CW-1:0] dst_chan;
  logic icb_cmd_valid = 1'b0, icb_cmd_ready, icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = '0, icb_cmd_wdata = '0, icb_rsp_rdata;
  logic [3:0] icb_cmd_wmask = '0;
  logic icb_rsp_valid, icb_rsp_ready = 1'b1, icb_rsp_err, dma_irq;
  logic [31:0] key = '0;

  always #5 clk = ~clk;
  assign src_data = src_addr ^ key;

  mvu_dma_mc #(.NCH(NCH), .SRC_AW(SRC_AW), .SRC_DW(SRC_DW), .DST_AW(DST_AW), .DST_DW(DST_DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_chan(dst_chan),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask), .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
    .dma_irq(dma_irq)
  );

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [DST_AW-1:0] addr;
    logic [DST_DW-1:0] data;
  } wr_t;
  typedef struct {
    logic rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] m;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;

  wr_t act_q[$], exp_q[$];
  logic [SRC_AW-1:0] rd_q[$];
  int checks = 0, errors = 0;
  int src_stall = 0, dst_stall = 0;
  bit rnd_rdy = 1'b0;

  initial begin
    src_ready = 1'b0;
    dst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (src_valid && src_stall > 0) begin
        src_ready = 1'b0;
        src_stall--;
      end else src_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (dst_valid && dst_stall > 0) begin
        dst_ready = 1'b0;
        dst_stall--;
      end else dst_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  logic pv_s = 1'b0, pv_d = 1'b0;
  logic [SRC_AW-1:0] p_sa;
  logic [DST_AW-1:0] p_da;
  logic [DST_DW-1:0] p_dd;
  logic [CW-1:0] p_dc;
  always @(negedge clk) begin
    if (rst) begin
      pv_s = 1'b0;
      pv_d = 1'b0;
    end else begin
      if (pv_s) begin
        checks++;
        if (!src_valid || src_addr !== p_sa) begin
          errors++;
          $display("FAIL src_hold: valid=%0b addr=0x%0h required valid=1 addr=0x%0h", src_valid, src_addr, p_sa);
        end
      end
      if (pv_d) begin
        checks++;
        if (!dst_valid || dst_addr !== p_da || dst_data !== p_dd || dst_chan !== p_dc) begin
          errors++;
          $display("FAIL dst_hold: valid=%0b addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h", dst_valid, dst_addr, dst_data, p_da, p_dd);
        end
      end
      if (src_valid && src_ready) rd_q.push_back(src_addr);
      if (dst_valid && dst_ready) act_q.push_back({dst_chan, dst_addr, dst_data});
      pv_s = src_valid && !src_ready;
      pv_d = dst_valid && !dst_ready;
      p_sa = src_addr;
      p_da = dst_addr;
      p_dd = dst_data;
      p_dc = dst_chan;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic icb(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                     output logic [31:0] rdat, output logic rerr);
    int n = 0;
    @(negedge clk);
    icb_cmd_valid = 1'b1;
    icb_cmd_read = rd;
    icb_cmd_addr = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = m;
    while (!icb_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    checks++;
    if (n >= 20 || !icb_rsp_valid) begin
      errors++;
      $display("FAIL icb_handshake addr 0x%0h: rsp_valid=%0b wait=%0d required rsp_valid=1", a, icb_rsp_valid, n);
    end
    rdat = icb_rsp_rdata;
    rerr = icb_rsp_err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    icb(1'b0, a, d, 4'hF, r, e);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    icb(1'b1, a, 32'd0, 4'hF, r, e);
    chk(nm, 64'(r), 64'(exp));
  endtask

  task automatic wait_idle(input int ch);
    logic [31:0] d;
    logic e;
    int n = 0;
    do begin
      icb(1'b1, 32'(ch * 16 + 12), 32'd0, 4'hF, d, e);
      n++;
    end while (d[0] && n < 300);
    chk("idle_timeout", 64'(d[0]), 64'd0);
  endtask

  // Expected writes follow directly from the descriptor: word i packs R consecutive source words.
  task automatic model(input int ch, input logic [31:0] s, input logic [DST_AW-1:0] d, input int len);
    for (int i = 0; i < len; i++) begin
      wr_t w;
      w.chan = CW'(ch);
      w.addr = DST_AW'(d + DST_AW'(i));
      for (int k = 0; k < R; k++) w.data[k*SRC_DW +: SRC_DW] = (s + 32'((i * R + k) * (SRC_DW / 8))) ^ key;
      exp_q.push_back(w);
    end
  endtask

  task automatic check_writes(input string nm);
    int idx;
    wr_t a;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) if (idx < 0 && exp_q[i].chan == a.chan) idx = i;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected write ch%0d addr 0x%0h data 0x%0h, required none", nm, a.chan, a.addr, a.data);
      end else begin
        chk({nm, "_addr"}, 64'(a.addr), 64'(exp_q[idx].addr));
        chk({nm, "_data"}, a.data, exp_q[idx].data);
        exp_q.delete(idx);
      end
    end
    chk({nm, "_missing"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  vec_t tv[16];
  initial begin
    logic [31:0] r;
    logic e;
    int n;
    tv[0]  = '{1'b0, 32'h000, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 32'h000, 32'h0, 4'hF, 32'h1234_5678, 1'b0};
    tv[2]  = '{1'b0, 32'h004, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 32'h004, 32'h0, 4'hF, 32'h0000_7FFF, 1'b0};
    tv[4]  = '{1'b0, 32'h008, 32'hABCD_1234, 4'hF, 32'h0, 1'b0};
    tv[5]  = '{1'b1, 32'h008, 32'h0, 4'hF, 32'h0000_1234, 1'b0};
    tv[6]  = '{1'b0, 32'h000, 32'h0000_DEAD, 4'h3, 32'h0, 1'b0};
    tv[7]  = '{1'b1, 32'h000, 32'h0, 4'hF, 32'h1234_5678, 1'b0};
    tv[8]  = '{1'b1, 32'h010, 32'h0, 4'hF, 32'h0, 1'b0};
    tv[9]  = '{1'b1, 32'h00C, 32'h0, 4'hF, 32'h0, 1'b0};
    tv[10] = '{1'b1, 32'h200, 32'h0, 4'hF, 32'h0, 1'b1};
    tv[11] = '{1'b1, 32'h020, 32'h0, 4'hF, 32'h0, 1'b1};
    tv[12] = '{1'b1, 32'h002, 32'h0, 4'hF, 32'h0, 1'b1};
    tv[13] = '{1'b0, 32'h01C, 32'h2, 4'hF, 32'h0, 1'b0};
    tv[14] = '{1'b1, 32'h01C, 32'h0, 4'hF, 32'h4, 1'b0};
    tv[15] = '{1'b0, 32'h300, 32'h5, 4'hF, 32'h0, 1'b1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_src_valid", 64'(src_valid), 64'd0);
    chk("rst_dst_valid", 64'(dst_valid), 64'd0);
    chk("rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(icb_rsp_err), 64'd0);
    chk("rst_irq", 64'(dma_irq), 64'd0);
    chk("rst_cmd_ready", 64'(icb_cmd_ready), 64'd1);
    chk("rst_src_addr", 64'(src_addr), 64'd0);
    chk("rst_dst_addr", 64'(dst_addr), 64'd0);

    for (int i = 0; i < 16; i++) begin
      icb(tv[i].rd, tv[i].a, tv[i].wd, tv[i].m, r, e);
      chk($sformatf("reg%0d_err", i), 64'(e), 64'(tv[i].exp_err));
      if (tv[i].rd) chk($sformatf("reg%0d_rdata", i), 64'(r), 64'(tv[i].exp_rd));
    end
    wr(32'h01C, 32'h0);

    // Basic two-word transfer on channel 0.
    wr(32'h000, 32'h1000);
    wr(32'h004, 32'h10);
    wr(32'h008, 32'd2);
    rd_q.delete();
    act_q.delete();
    model(0, 32'h1000, 15'h10, 2);
    wr(32'h00C, 32'h3);
    wait_idle(0);
    chk("basic_rd_count", 64'(rd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("basic_rd_addr", (rd_q.size() > i) ? 64'(rd_q[i]) : 64'hX, 64'(32'h1000 + 32'(4 * i)));
    chk("basic_w0", (act_q.size() > 0) ? act_q[0].data : 64'hX, 64'h00001004_00001000);
    chk("basic_w1", (act_q.size() > 1) ? act_q[1].data : 64'hX, 64'h0000100C_00001008);
    check_writes("basic");
    rdchk("basic_ctrl", 32'h00C, 32'h6);
    chk("basic_irq", 64'(dma_irq), 64'd1);
    rdchk("basic_irqstat", 32'h100, 32'h1);

    // Stalls on both sides, then W1C of done.
    src_stall = 3;
    dst_stall = 5;
    wr(32'h000, 32'h2000);
    wr(32'h004, 32'h20);
    wr(32'h008, 32'd1);
    model(0, 32'h2000, 15'h20, 1);
    wr(32'h00C, 32'h3);
    wait_idle(0);
    chk("stall_w0", (act_q.size() > 0) ? act_q[0].data : 64'hX, 64'h00002004_00002000);
    check_writes("stall");
    wr(32'h00C, 32'h6);
    chk("w1c_irq", 64'(dma_irq), 64'd0);
    rdchk("w1c_ctrl", 32'h00C, 32'h4);

    // Arbitration: channel 0 then channel 1, twice.
    for (int rep = 0; rep < 2; rep++) begin
      wr(32'h000, 32'h3000); wr(32'h004, 32'h30); wr(32'h008, 32'd1);
      wr(32'h010, 32'h4000); wr(32'h014, 32'h40); wr(32'h018, 32'd1);
      model(0, 32'h3000, 15'h30, 1);
      model(1, 32'h4000, 15'h40, 1);
      wr(32'h00C, 32'h1);
      wr(32'h01C, 32'h1);
      wait_idle(0);
      wait_idle(1);
      chk("arb_count", 64'(act_q.size()), 64'd2);
      chk("arb_first", (act_q.size() > 0) ? 64'(act_q[0].chan) : 64'hX, 64'd0);
      chk("arb_second", (act_q.size() > 1) ? 64'(act_q[1].chan) : 64'hX, 64'd1);
      check_writes("arb");
    end

    // Zero-length start and start-while-busy.
    wr(32'h018, 32'd0);
    rd_q.delete();
    act_q.delete();
    wr(32'h01C, 32'h1);
    repeat (10) @(negedge clk);
    chk("len0_reads", 64'(rd_q.size()), 64'd0);
    chk("len0_writes", 64'(act_q.size()), 64'd0);
    rdchk("len0_ctrl", 32'h01C, 32'hA);
    dst_stall = 5;
    wr(32'h000, 32'h5000); wr(32'h004, 32'h50); wr(32'h008, 32'd3);
    model(0, 32'h5000, 15'h50, 3);
    wr(32'h00C, 32'h1);
    wr(32'h000, 32'h9999_0000);
    wr(32'h008, 32'd7);
    wr(32'h00C, 32'h1);
    wait_idle(0);
    check_writes("busy_start");
    rdchk("busy_ctrl", 32'h00C, 32'hA);
    rdchk("busy_shadow", 32'h000, 32'h9999_0000);

    // Source and destination address wrap.
    key = 32'h5A5A_0000;
    wr(32'h010, 32'hFFFF_FFFC); wr(32'h014, 32'h7FFF); wr(32'h018, 32'd2);
    model(1, 32'hFFFF_FFFC, 15'h7FFF, 2);
    wr(32'h01C, 32'h1);
    wait_idle(1);
    chk("wrap_a0", (act_q.size() > 0) ? 64'(act_q[0].addr) : 64'hX, 64'h7FFF);
    chk("wrap_a1", (act_q.size() > 1) ? 64'(act_q[1].addr) : 64'hX, 64'h0);
    check_writes("wrap");

    // Randomized descriptors and ready patterns.
    rnd_rdy = 1'b1;
    for (int it = 0; it < 12; it++) begin
      logic [31:0] s;
      logic [DST_AW-1:0] d;
      int l;
      key = $urandom;
      for (int c = 0; c < NCH; c++) begin
        if (c == 0 || $urandom_range(0, 1) == 1) begin
          s = $urandom & 32'hFFFF_FFFC;
          d = DST_AW'($urandom);
          l = $urandom_range(1, 4);
          wr(32'(c * 16), s);
          wr(32'(c * 16 + 4), 32'(d));
          wr(32'(c * 16 + 8), 32'(l));
          model(c, s, d, l);
          wr(32'(c * 16 + 12), 32'h1);
        end
      end
      wait_idle(0);
      wait_idle(1);
      check_writes("rand");
    end
    rnd_rdy = 1'b0;

    // Reset in the middle of a read phase.
    src_stall = 100;
    wr(32'h000, 32'h6000); wr(32'h004, 32'h60); wr(32'h008, 32'd4);
    wr(32'h00C, 32'h3);
    n = 0;
    while (!src_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_read", 64'(src_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_src_valid", 64'(src_valid), 64'd0);
    chk("midrst_dst_valid", 64'(dst_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(icb_cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    src_stall = 0;
    for (int a = 0; a < 32; a += 4) rdchk($sformatf("midrst_reg%0h", a), 32'(a), 32'h0);
    rdchk("midrst_irqstat", 32'h100, 32'h0);
    chk("midrst_irq", 64'(dma_irq), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mvu_dma_mc.md
Name: mvu_dma_mc

Overview:
- Multi-channel, width-parametrised successor to the single-channel MVU DMA.
- Each of NCH channels has its own descriptor: source address, destination address and length.
- A round-robin engine reads SRC_DW-bit words from system memory and packs DST_DW/SRC_DW of them LSB-first into one destination word. It writes that word to the MVU buffer port.
- Configuration goes through a simple ICB slave. A masked per-channel completion interrupt is provided.

Parameters:
- NCH, 2, number of channels (1..8).
- SRC_AW, 32, source address width.
- SRC_DW, 32, source data width; a power of two, at least 8.
- DST_AW, 15, destination word-address width.
- DST_DW, 64, destination data width; an integer multiple of SRC_DW.
- LEN_W, 16, width of the length field, counted in destination words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- src_addr  out  SRC_AW  source byte address.
- src_valid  out  1  read request.
- src_ready  in  1  request accepted; src_data is valid in the same cycle.
- src_data  in  SRC_DW  read data.
- dst_addr  out  DST_AW  destination word address.
- dst_data  out  DST_DW  packed word.
- dst_chan  out  $clog2(NCH) (minimum 1)  channel that owns the current write.
- dst_valid  out  1  write request.
- dst_ready  in  1  write accepted.
- icb_cmd_valid/icb_cmd_ready  in/out  1  command handshake.
- icb_cmd_addr  in  32  register address; bits [11:0] are decoded.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte mask; only all-ones writes take effect.
- icb_rsp_valid/icb_rsp_ready  out/in  1  response handshake.
- icb_rsp_err  out  1  set when the address is unmapped.
- icb_rsp_rdata  out  32  read data.
- dma_irq  out  1  OR of (done & irq_en) across channels.

Behaviour:
- Register map, channel c at base c*0x10:
  - +0x0 SRC (RW).
  - +0x4 DST (RW, low DST_AW bits).
  - +0x8 LEN (RW, low LEN_W bits).
  - +0xC CTRL.
    - Write: bit0 start (self-clearing), bit1 irq_en, bit2 done clear (W1C).
    - Read: bit0 busy, bit1 done, bit2 irq_en, bit3 err.
- 0x100 IRQ_STAT: bit c = done[c] & irq_en[c]; read-only. Any other address -> rsp_err=1, rdata=0, no side effect.
- ICB timing:
  - icb_cmd_ready = !icb_rsp_valid, so only one transaction is outstanding.
  - Response is presented the cycle after accept and held until icb_rsp_ready.
  - Register write effects are visible the cycle after accept.
- Start:
  - If the channel is idle and LEN != 0: busy=1, done=0, err=0, and working copies of SRC/DST/LEN are latched.
  - If LEN == 0: err=1 and done=1 in the same update, no transfer.
  - If the channel is busy: start is ignored and err=1.
- Writes to SRC/DST/LEN while busy only update the shadow registers; the running transfer is unaffected.
- Engine FSM states: IDLE, READ, WRITE, FIN.
  - IDLE: round-robin pick among busy channels, starting after the last serviced channel. The chosen channel keeps the engine for its whole transfer. -> READ.
  - READ:
    - src_valid=1, src_addr = working src.
    - On src_valid & src_ready: put src_data into slot k of the packing register (bits k*SRC_DW+:SRC_DW), src += SRC_DW/8, k++.
    - When k reaches DST_DW/SRC_DW: -> WRITE, k=0.
  - WRITE:
    - dst_valid=1, dst_addr/dst_data/dst_chan held stable until dst_ready.
    - On accept: dst += 1 (wraps modulo 2^DST_AW), len -= 1.
    - If len reaches 0 -> FIN, else -> READ.
  - FIN: busy=0, done=1 for the channel; -> IDLE. One cycle.
- Throughput:
  - Back-to-back source beats are allowed: one word per cycle while src_ready=1.
  - A transfer of L words takes at least L*(DST_DW/SRC_DW + 1) + 2 cycles.
- Source address wraps modulo 2^SRC_AW.
- If a done-clear W1C and FIN hit the same channel in the same cycle, FIN wins (done=1).
- dma_irq is combinational from the registers. It is asserted the cycle after FIN when irq_en=1.
- Reset values:
  - Registers: all 0.
  - FSM: IDLE; round-robin pointer: channel NCH-1, so channel 0 has first priority.
  - Outputs: src_valid, dst_valid, icb_rsp_valid, icb_rsp_err, dma_irq all 0; data/address outputs 0; icb_cmd_ready=1.
- Reset asserted mid-transfer aborts it: no further src/dst requests are issued and all channel state is cleared.

Test Plan:
- Ch0: SRC=0x1000, DST=0x10, LEN=2, src_data = address. Expect 4 reads at 0x1000/4/8/C, then 2 writes: dst_addr 0x10 = 0x00001004_00001000 and 0x11 = 0x0000100C_00001008. After that busy=0, done=1, dma_irq=1 with irq_en set.
- Stall handling: hold src_ready low 3 cycles and dst_ready low 5 cycles -> src_addr, dst_addr and dst_data stay stable while stalled and the final data is unchanged; W1C done clears dma_irq.
- Arbitration: start ch0 and ch1 in consecutive cycles, LEN=1 each -> ch0 runs to completion first with dst_chan=0, then ch1 with dst_chan=1. Restart both -> ch0 is serviced first again because the pointer sits at ch1.
- Errors: LEN=0 start -> err=1, done=1, no bus activity. Start ch0 while busy -> err=1, transfer unaffected. Read 0x200 -> rsp_err=1.
- Wrap: DST=0x7FFF, LEN=2 -> writes land at 0x7FFF then 0x0000.
- Assert rst mid-READ -> the next cycle has src_valid=0, dst_valid=0 and every register reads 0.
